// File: rtl/seq_gen_if.sv
// Control/serial-output bundle of the seq_gen pattern transmitter.
// master drives the job request, slave is the transmitter itself.
interface seq_gen_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             abort;
   logic             use_default;
   logic [WIDTH-1:0] pattern_in;
   logic [3:0]       repeat_cnt;
   logic             data;
   logic             data_vld;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, use_default, pattern_in, repeat_cnt,
      input  data, data_vld, busy, done
   );

   modport slave (
      input  start, abort, use_default, pattern_in, repeat_cnt,
      output data, data_vld, busy, done
   );
endinterface

// File: rtl/seq_gen.sv
// Bit-serial pattern transmitter: sends a WIDTH-bit frame MSB-first with a valid
// strobe, optionally repeated with GAP_CYCLES idle cycles between frames.
module seq_gen #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] PATTERN    = 8'b1101_1001,
   parameter int               GAP_CYCLES = 0
) (
   input logic      clk,
   input logic      rst_n,
   seq_gen_if.slave bus
);
   localparam int IW = $clog2(WIDTH);
   // Keep the gap counter at least 1 bit wide so GAP_CYCLES=0 still elaborates.
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] pat_q;
   logic [IW-1:0]    bit_idx_q;
   logic [GW-1:0]    gap_q;
   logic [3:0]       reps_q;
   logic             data_q;
   logic             vld_q;
   logic             busy_q;
   logic             done_q;

   logic [IW-1:0]    idx_dec;
   logic [WIDTH-1:0] pat_sel;

   assign idx_dec = bit_idx_q - IW'(1);
   assign pat_sel = bus.use_default ? PATTERN : bus.pattern_in;

   // bit_idx_q always names the bit currently presented on data_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         bit_idx_q <= '0;
         gap_q     <= '0;
         reps_q    <= '0;
         data_q    <= 1'b0;
         vld_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.abort) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            gap_q     <= '0;
            reps_q    <= '0;
            data_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     state_q   <= SHIFT;
                     pat_q     <= pat_sel;
                     reps_q    <= (bus.repeat_cnt == 4'd0) ? 4'd1 : bus.repeat_cnt;
                     bit_idx_q <= IW'(WIDTH - 1);
                     data_q    <= pat_sel[WIDTH-1];
                     vld_q     <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (bit_idx_q != '0) begin
                     bit_idx_q <= idx_dec;
                     data_q    <= pat_q[idx_dec];
                  end else if (reps_q > 4'd1) begin
                     reps_q <= reps_q - 4'd1;
                     if (GAP_CYCLES > 0) begin
                        state_q <= GAP;
                        gap_q   <= GW'(GAP_CYCLES - 1);
                        data_q  <= 1'b0;
                        vld_q   <= 1'b0;
                     end else begin
                        bit_idx_q <= IW'(WIDTH - 1);
                        data_q    <= pat_q[WIDTH-1];
                     end
                  end else begin
                     state_q <= IDLE;
                     reps_q  <= '0;
                     data_q  <= 1'b0;
                     vld_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               GAP: begin
                  if (gap_q != '0) begin
                     gap_q <= gap_q - GW'(1);
                  end else begin
                     state_q   <= SHIFT;
                     bit_idx_q <= IW'(WIDTH - 1);
                     data_q    <= pat_q[WIDTH-1];
                     vld_q     <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.data     = data_q;
   assign bus.data_vld = vld_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
